// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: shares the register-file write port between ALU (A) and load (B) sources,
// with a registered output stage and a pending-write scoreboard that drives operand stalls.
module reg_wb_arbiter #(
  parameter bit          RR_EN  = 1'b1,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              stall,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] w_data,
  output logic [5:0]        pend_cnt
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic               rr_q, rr_d;  // 0: A has priority, 1: B has priority
  logic [ADDR_W-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0]  w_data_q, w_data_d;
  logic [NumRegs-1:0] pend_q, pend_d;
  logic [5:0]         cnt_q, cnt_d;
  logic               grant_a, grant_b;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      if (a_valid && b_valid) begin
        grant_a = RR_EN ? !rr_q : 1'b1;
        grant_b = !grant_a;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  always_comb begin
    rr_d     = rr_q;
    rd_d     = '0;
    w_data_d = w_data_q;
    if (RR_EN && a_valid && b_valid) rr_d = !rr_q;
    if (grant_a) begin
      rd_d     = a_rd;
      w_data_d = a_data;
    end else if (grant_b) begin
      rd_d     = b_rd;
      w_data_d = b_data;
    end
  end

  // Clear on the edge the register file writes; a same-edge issue re-reserves (set wins).
  always_comb begin
    pend_d = pend_q;
    if (rd_q != '0) pend_d[rd_q] = 1'b0;
    if (issue_valid && issue_rd != '0) pend_d[issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
    cnt_d = '0;
    for (int i = 0; i < NumRegs; i++) cnt_d = cnt_d + 6'(pend_d[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q     <= 1'b0;
      rd_q     <= '0;
      w_data_q <= '0;
      pend_q   <= '0;
      cnt_q    <= '0;
    end else begin
      rr_q     <= rr_d;
      rd_q     <= rd_d;
      w_data_q <= w_data_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stall    = ((rs != '0) && pend_q[rs]) || ((rt != '0) && pend_q[rt]);
  assign rd       = rd_q;
  assign w_data   = w_data_q;
  assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority instance share one stimulus.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, issue_valid;
  logic [4:0]  a_rd, b_rd, issue_rd, rs, rt;
  logic [31:0] a_data, b_data;

  logic        a_ready, b_ready, stall;
  logic [4:0]  rd;
  logic [31:0] w_data;
  logic [5:0]  pend_cnt;

  logic        a_ready0, b_ready0, stall0;
  logic [4:0]  rd0;
  logic [31:0] w_data0;
  logic [5:0]  pend_cnt0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_wb_arbiter #(.RR_EN(1'b1), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs(rs), .rt(rt),
    .stall(stall), .rd(rd), .w_data(w_data), .pend_cnt(pend_cnt)
  );

  reg_wb_arbiter #(.RR_EN(1'b0), .DATA_W(32), .ADDR_W(5)) dut0 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready0), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready0), .b_rd(b_rd), .b_data(b_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs(rs), .rt(rt),
    .stall(stall0), .rd(rd0), .w_data(w_data0), .pend_cnt(pend_cnt0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; issue_valid = 1'b0;
    a_rd = 5'd1; b_rd = 5'd2; a_data = 32'd0; b_data = 32'd0;
    issue_rd = 5'd0; rs = 5'd0; rt = 5'd0;
    #2;
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    tick();
    tick();
    chk("rst_a_ready2", 32'(a_ready), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_w_data", w_data, 32'd0);
    chk("rst_pend_cnt", 32'(pend_cnt), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    tick();

    // Single write from A
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
    #1;
    chk("single_a_ready", 32'(a_ready), 32'd1);
    chk("single_b_ready", 32'(b_ready), 32'd0);
    tick();
    a_valid = 1'b0;
    chk("single_rd", 32'(rd), 32'd5);
    chk("single_w_data", w_data, 32'hDEADBEEF);
    tick();
    chk("single_rd_idle", 32'(rd), 32'd0);
    chk("single_w_hold", w_data, 32'hDEADBEEF);

    // Contention: RR grants A,B,A,B; fixed priority grants A every cycle
    a_valid = 1'b1; b_valid = 1'b1;
    a_rd = 5'd1; a_data = 32'h11; b_rd = 5'd2; b_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_a_ready%0d", i), 32'(a_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr_b_ready%0d", i), 32'(b_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("fp_a_ready%0d", i), 32'(a_ready0), 32'd1);
      chk($sformatf("fp_b_ready%0d", i), 32'(b_ready0), 32'd0);
      tick();
      chk($sformatf("rr_rd%0d", i), 32'(rd), (i % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("rr_w_data%0d", i), w_data, (i % 2 == 0) ? 32'h11 : 32'h22);
      chk($sformatf("fp_rd%0d", i), 32'(rd0), 32'd1);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    chk("cont_rd_idle", 32'(rd), 32'd0);

    // Scoreboard: reserve r7, then retire it via B
    issue_valid = 1'b1; issue_rd = 5'd7; rs = 5'd7;
    #1;
    chk("sb_no_bypass", 32'(stall), 32'd0);
    tick();
    issue_valid = 1'b0;
    chk("sb_stall", 32'(stall), 32'd1);
    chk("sb_cnt1", 32'(pend_cnt), 32'd1);
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h77;
    #1;
    chk("sb_b_ready", 32'(b_ready), 32'd1);
    tick();
    b_valid = 1'b0;
    chk("sb_rd7", 32'(rd), 32'd7);
    chk("sb_stall_held", 32'(stall), 32'd1);
    tick();
    chk("sb_stall_drop", 32'(stall), 32'd0);
    chk("sb_cnt0", 32'(pend_cnt), 32'd0);
    rs = 5'd0;

    // Issue of r0 reserves nothing
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    issue_valid = 1'b0;
    chk("r0_issue_cnt", 32'(pend_cnt), 32'd0);

    // Set and clear of r3 on the same edge: set wins
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h33;
    tick();
    a_valid = 1'b0;
    chk("coll_rd3", 32'(rd), 32'd3);
    issue_valid = 1'b1; issue_rd = 5'd3; rt = 5'd3;
    tick();
    issue_valid = 1'b0;
    chk("coll_stall", 32'(stall), 32'd1);
    chk("coll_cnt", 32'(pend_cnt), 32'd1);

    // A write to r0 takes the grant but produces no write
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h55;
    #1;
    chk("r0_a_ready", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0;
    chk("r0_rd", 32'(rd), 32'd0);
    chk("r0_w_data", w_data, 32'h55);
    chk("r0_cnt", 32'(pend_cnt), 32'd1);

    // Reset while r9 is being presented and pending
    issue_valid = 1'b1; issue_rd = 5'd9;
    a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h99;
    tick();
    issue_valid = 1'b0; a_valid = 1'b0; rs = 5'd9;
    chk("mid_rd9", 32'(rd), 32'd9);
    chk("mid_cnt2", 32'(pend_cnt), 32'd2);
    chk("mid_stall", 32'(stall), 32'd1);
    rst = 1'b1; a_valid = 1'b1;
    #1;
    chk("mid_rst_a_ready", 32'(a_ready), 32'd0);
    tick();
    rst = 1'b0; a_valid = 1'b0;
    chk("mid_rst_rd", 32'(rd), 32'd0);
    chk("mid_rst_cnt", 32'(pend_cnt), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_w_data", w_data, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
